// File: rtl/sp_grant_lock_mux.sv
// Packet-level strict-priority arbiter and mux: the winning source stays locked until its
// last beat is accepted. A watchdog releases the lock if the granted source stalls.
module sp_grant_lock_mux #(
    parameter int NUM      = 4,
    parameter int DW       = 8,
    parameter int LSB_HIGH = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM-1:0]    s_valid_i,
    input  logic [NUM*DW-1:0] s_data_i,
    input  logic [NUM-1:0]    s_last_i,
    output logic [NUM-1:0]    s_ready_o,
    output logic              m_valid_o,
    output logic [DW-1:0]     m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [NUM-1:0]    gnt_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]     state;
    logic [NUM-1:0] gnt;
    logic [NUM-1:0] winner;
    logic [CW-1:0]  wd_cnt;
    logic           tmo;
    logic           mux_valid;
    logic           mux_last;
    logic [DW-1:0]  mux_data;
    logic           hs;
    logic           hs_last;
    logic           wd_fire;

    // Iterate from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = '0;
        if (LSB_HIGH != 0) begin
            for (int i = NUM - 1; i >= 0; i--) begin
                if (s_valid_i[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (s_valid_i[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mux_valid = 1'b0;
        mux_last  = 1'b0;
        mux_data  = '0;
        for (int k = 0; k < NUM; k++) begin
            if (gnt[k]) begin
                mux_valid = s_valid_i[k];
                mux_last  = s_last_i[k];
                mux_data  = s_data_i[k*DW +: DW];
            end
        end
    end

    // gnt is zero outside LOCK, so the mux is silent when idle; reset blocks any beat at once.
    always_comb begin
        m_valid_o = mux_valid & ~rst_i;
        m_data_o  = m_valid_o ? mux_data : '0;
        m_last_o  = m_valid_o & mux_last;
        s_ready_o = rst_i ? '0 : (gnt & {NUM{m_ready_i}});
        hs        = m_valid_o & m_ready_i;
        hs_last   = hs & m_last_o;
        wd_fire   = (TIMEOUT > 0) && (state == LOCK) && !hs && (wd_cnt == CW'(TIMEOUT - 1));
    end

    // wd_cnt holds the stalled cycles already seen; the TIMEOUT-th stalled cycle releases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            gnt    <= '0;
            wd_cnt <= '0;
            tmo    <= 1'b0;
        end else begin
            tmo <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|s_valid_i) begin
                        gnt   <= winner;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (hs_last) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        wd_cnt <= '0;
                    end else if (wd_fire) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        wd_cnt <= '0;
                        tmo    <= 1'b1;
                    end else if (hs) begin
                        wd_cnt <= '0;
                    end else if (TIMEOUT > 0) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt_o     = gnt;
    assign busy_o    = (state == LOCK);
    assign timeout_o = tmo;

endmodule
